// File: rtl/cc_itf_pkg.sv
// CoreComplex interface package: reqrsp AMO encoding, APB bridge state,
// default peripheral map and the APB request/response struct pattern.
package cc_itf_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'h0,
    AMO_SWAP = 4'h1,
    AMO_ADD  = 4'h2,
    AMO_AND  = 4'h3,
    AMO_OR   = 4'h4,
    AMO_XOR  = 4'h5,
    AMO_MAX  = 4'h6,
    AMO_MAXU = 4'h7,
    AMO_MIN  = 4'h8,
    AMO_MINU = 4'h9,
    AMO_LR   = 4'hA,
    AMO_SC   = 4'hB
  } amo_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_bridge_state_e;

  localparam int unsigned APB_SLV_NUM = 3;
  localparam logic [APB_SLV_NUM*32-1:0] SLV_BASE_DEFAULT =
    {32'h1000_3000, 32'h1000_2000, 32'h1000_1000};
  localparam logic [APB_SLV_NUM*32-1:0] SLV_MASK_DEFAULT = {3{32'hFFFF_F000}};

  // One req/resp pair per supported APB data width (32 and 64).
  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_dw32_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_resp_dw32_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
  } apb_req_dw64_t;

  typedef struct packed {
    logic [63:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_resp_dw64_t;

  // APB beats needed for an access of 2**size bytes, capped at the width ratio.
  function automatic int unsigned apb_num_beats(input logic [1:0] size,
                                                input int unsigned abytes_log2,
                                                input int unsigned ratio);
    int unsigned nb;
    if ({30'd0, size} <= abytes_log2) nb = 32'd1;
    else nb = 32'd1 << ({30'd0, size} - abytes_log2);
    if (nb > ratio) nb = ratio;
    else nb = nb;
    return nb;
  endfunction

endpackage

// File: rtl/cc_apb_addr_decode.sv
// Combinational APB address decoder: one-hot completer select plus hit flag,
// lowest index wins on overlapping windows.
module cc_apb_addr_decode
  import cc_itf_pkg::*;
#(
  parameter int unsigned NUM_SLV    = APB_SLV_NUM,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = SLV_BASE_DEFAULT,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK = SLV_MASK_DEFAULT
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLV-1:0]    sel_o,
  output logic                  hit_o
);

  logic [NUM_SLV-1:0] match_s;
  logic [NUM_SLV-1:0] sel_s;
  logic               hit_s;

  // Per-completer window compare.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      match_s[i] = ((addr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                    SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // Priority pick of the first matching completer.
  always_comb begin
    sel_s = '0;
    hit_s = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (match_s[i] && !hit_s) begin
        sel_s[i] = 1'b1;
        hit_s    = 1'b1;
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  assign sel_o = sel_s;
  assign hit_o = hit_s;

endmodule

// File: rtl/cc_reqrsp_to_apb_bridge.sv
// Single-outstanding bridge from a reqrsp port to N APB completers, splitting
// wide accesses into APB beats, rejecting AMOs and bounding each beat's wait.
module cc_reqrsp_to_apb_bridge
  import cc_itf_pkg::*;
#(
  parameter int unsigned NUM_APB_SLV    = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REQ_DATA_WIDTH = 64,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter logic [NUM_APB_SLV*ADDR_WIDTH-1:0] SLV_BASE = SLV_BASE_DEFAULT,
  parameter logic [NUM_APB_SLV*ADDR_WIDTH-1:0] SLV_MASK = SLV_MASK_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [ADDR_WIDTH-1:0]              q_addr_i,
  input  logic                               q_write_i,
  input  logic [3:0]                         q_amo_i,
  input  logic [REQ_DATA_WIDTH-1:0]          q_data_i,
  input  logic [REQ_DATA_WIDTH/8-1:0]        q_strb_i,
  input  logic [1:0]                         q_size_i,
  input  logic                               q_valid_i,
  output logic                               q_ready_o,
  output logic [REQ_DATA_WIDTH-1:0]          p_data_o,
  output logic                               p_error_o,
  output logic                               p_valid_o,
  input  logic                               p_ready_i,
  output logic [ADDR_WIDTH-1:0]              paddr_o,
  output logic [2:0]                         pprot_o,
  output logic [NUM_APB_SLV-1:0]             psel_o,
  output logic                               penable_o,
  output logic                               pwrite_o,
  output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
  output logic [APB_DATA_WIDTH/8-1:0]        pstrb_o,
  input  logic [NUM_APB_SLV*APB_DATA_WIDTH-1:0] prdata_i,
  input  logic [NUM_APB_SLV-1:0]             pready_i,
  input  logic [NUM_APB_SLV-1:0]             pslverr_i
);

  localparam int unsigned RATIO  = REQ_DATA_WIDTH / APB_DATA_WIDTH;
  localparam int unsigned ABYTES = APB_DATA_WIDTH / 8;
  localparam int unsigned RBYTES = REQ_DATA_WIDTH / 8;
  localparam int unsigned ALSB   = $clog2(ABYTES);
  localparam int unsigned BW     = $clog2(RATIO) + 1;
  localparam int unsigned LW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]                state_r;
  logic                      ready_en_r;
  logic [NUM_APB_SLV-1:0]    sel_r;
  logic                      write_r;
  logic [REQ_DATA_WIDTH-1:0] data_r;
  logic [RBYTES-1:0]         strb_r;
  logic [ADDR_WIDTH-1:0]     base_r;
  logic [LW-1:0]             lane0_r;
  logic [BW-1:0]             nbeats_r;
  logic [BW-1:0]             beat_r;
  logic [REQ_DATA_WIDTH-1:0] rdata_r;
  logic                      err_r;
  logic [TW-1:0]             tcnt_r;

  logic [NUM_APB_SLV-1:0]    dec_sel_s;
  logic                      dec_hit_s;
  logic [BW-1:0]             nbeats_s;
  logic [LW-1:0]             lane_s;
  logic [ADDR_WIDTH-1:0]     base_s;
  logic [LW-1:0]             cur_lane_s;
  logic                      last_beat_s;
  logic [APB_DATA_WIDTH-1:0] sel_prdata_s;
  logic                      sel_pready_s;
  logic                      sel_pslverr_s;

  cc_apb_addr_decode #(
    .NUM_SLV    (NUM_APB_SLV),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_addr_decode (
    .addr_i (q_addr_i),
    .sel_o  (dec_sel_s),
    .hit_o  (dec_hit_s)
  );

  // Beat plan: narrow accesses use their own lane, wide ones start at lane 0.
  always_comb begin
    nbeats_s = BW'(apb_num_beats(q_size_i, ALSB, RATIO));
    if ({30'd0, q_size_i} <= ALSB) begin
      lane_s = LW'(q_addr_i >> ALSB) & LW'(RATIO - 1);
      base_s = q_addr_i & ~ADDR_WIDTH'(ABYTES - 1);
    end else begin
      lane_s = '0;
      base_s = q_addr_i & ~ADDR_WIDTH'(RBYTES - 1);
    end
  end

  // Fold the selected completer's response signals.
  always_comb begin
    sel_prdata_s = '0;
    for (int i = 0; i < NUM_APB_SLV; i++) begin
      sel_prdata_s = sel_prdata_s |
        (prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] & {APB_DATA_WIDTH{sel_r[i]}});
    end
  end

  assign sel_pready_s  = |(pready_i & sel_r);
  assign sel_pslverr_s = |(pslverr_i & sel_r);
  assign cur_lane_s    = lane0_r + LW'(beat_r);
  assign last_beat_s   = (beat_r == (nbeats_r - BW'(1)));

  assign q_ready_o = ready_en_r && (state_r == ST_IDLE);
  assign p_valid_o = (state_r == ST_RESP);
  assign p_data_o  = rdata_r;
  assign p_error_o = err_r;
  assign psel_o    = ((state_r == ST_SETUP) || (state_r == ST_ACCESS)) ? sel_r : '0;
  assign penable_o = (state_r == ST_ACCESS);
  assign pprot_o   = 3'b000;
  assign paddr_o   = base_r + (ADDR_WIDTH'(beat_r) << ALSB);
  assign pwrite_o  = write_r;
  assign pwdata_o  = data_r[int'(cur_lane_s)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  assign pstrb_o   = write_r ? strb_r[int'(cur_lane_s)*ABYTES +: ABYTES] : '0;

  // Transaction sequencer: accept, run the APB beats, hold the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      ready_en_r <= 1'b0;
      sel_r      <= '0;
      write_r    <= 1'b0;
      data_r     <= '0;
      strb_r     <= '0;
      base_r     <= '0;
      lane0_r    <= '0;
      nbeats_r   <= '0;
      beat_r     <= '0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      tcnt_r     <= '0;
    end else begin
      ready_en_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (q_ready_o && q_valid_i) begin
            write_r  <= q_write_i;
            data_r   <= q_data_i;
            strb_r   <= q_strb_i;
            sel_r    <= dec_sel_s;
            base_r   <= base_s;
            lane0_r  <= lane_s;
            nbeats_r <= nbeats_s;
            beat_r   <= '0;
            tcnt_r   <= '0;
            rdata_r  <= '0;
            if ((q_amo_i != AMO_NONE) || !dec_hit_s) begin
              err_r   <= 1'b1;
              state_r <= ST_RESP;
            end else begin
              err_r   <= 1'b0;
              state_r <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          tcnt_r  <= '0;
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (sel_pready_s) begin
            if (!write_r) begin
              rdata_r[int'(cur_lane_s)*APB_DATA_WIDTH +: APB_DATA_WIDTH] <= sel_prdata_s;
            end
            err_r <= err_r | sel_pslverr_s;
            if (last_beat_s) begin
              state_r <= ST_RESP;
            end else begin
              beat_r  <= beat_r + BW'(1);
              state_r <= ST_SETUP;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (tcnt_r == TO_LAST)) begin
            // Abandon the remaining beats; the response reports the error.
            err_r   <= 1'b1;
            state_r <= ST_RESP;
          end else if (tcnt_r != {TW{1'b1}}) begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        ST_RESP: begin
          if (p_ready_i) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_reqrsp_to_apb_bridge.sv
// Directed bench for cc_reqrsp_to_apb_bridge with hand-computed expectations.
module tb_cc_reqrsp_to_apb_bridge;
  import cc_itf_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] q_addr_i;
  logic        q_write_i;
  logic [3:0]  q_amo_i;
  logic [63:0] q_data_i;
  logic [7:0]  q_strb_i;
  logic [1:0]  q_size_i;
  logic        q_valid_i;
  logic        q_ready_o;
  logic [63:0] p_data_o;
  logic        p_error_o;
  logic        p_valid_o;
  logic        p_ready_i;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic [2:0]  psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [95:0] prdata_i;
  logic [2:0]  pready_i;
  logic [2:0]  pslverr_i;

  int n_chk = 0;
  int n_err = 0;

  cc_reqrsp_to_apb_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .q_addr_i(q_addr_i), .q_write_i(q_write_i), .q_amo_i(q_amo_i),
    .q_data_i(q_data_i), .q_strb_i(q_strb_i), .q_size_i(q_size_i),
    .q_valid_i(q_valid_i), .q_ready_o(q_ready_o),
    .p_data_o(p_data_o), .p_error_o(p_error_o), .p_valid_o(p_valid_o),
    .p_ready_i(p_ready_i),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Handshake at the end of cycle 0; returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] amo,
                       input logic [63:0] data, input logic [7:0] strb, input logic [1:0] size);
    @(negedge clk_i);
    q_addr_i  = addr;
    q_write_i = wr;
    q_amo_i   = amo;
    q_data_i  = data;
    q_strb_i  = strb;
    q_size_i  = size;
    q_valid_i = 1'b1;
    check("q_ready_idle", q_ready_o, 64'd1);
    @(negedge clk_i);
    q_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"}, psel_o, 64'd0);
    check({tag, "_penable"}, penable_o, 64'd0);
    check({tag, "_p_valid"}, p_valid_o, 64'd0);
    check({tag, "_q_ready"}, q_ready_o, 64'd0);
    check({tag, "_p_data"}, p_data_o, 64'd0);
    check({tag, "_p_error"}, p_error_o, 64'd0);
    check({tag, "_paddr"}, paddr_o, 64'd0);
    check({tag, "_pwrite"}, pwrite_o, 64'd0);
    check({tag, "_pwdata"}, pwdata_o, 64'd0);
    check({tag, "_pstrb"}, pstrb_o, 64'd0);
    check({tag, "_pprot"}, pprot_o, 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; q_addr_i = 32'd0; q_write_i = 1'b0; q_amo_i = AMO_NONE;
    q_data_i = 64'd0; q_strb_i = 8'd0; q_size_i = 2'd0; q_valid_i = 1'b0;
    p_ready_i = 1'b1; prdata_i = 96'd0; pready_i = 3'b111; pslverr_i = 3'b000;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 32b read from slave 1, upper lane
    prdata_i = {32'h0, 32'hDEAD_BEEF, 32'h0};
    issue(32'h1000_2004, 1'b0, AMO_NONE, 64'd0, 8'h00, 2'd2);
    check("rd_setup_psel", psel_o, 64'h2);
    check("rd_setup_penable", penable_o, 64'd0);
    check("rd_setup_paddr", paddr_o, 64'h1000_2004);
    check("rd_setup_pwrite", pwrite_o, 64'd0);
    check("rd_setup_pstrb", pstrb_o, 64'd0);
    check("rd_setup_q_ready", q_ready_o, 64'd0);
    @(negedge clk_i);
    check("rd_access_penable", penable_o, 64'd1);
    check("rd_access_psel", psel_o, 64'h2);
    @(negedge clk_i);
    check("rd_p_valid_c3", p_valid_o, 64'd1);
    check("rd_p_data", p_data_o, 64'hDEAD_BEEF_0000_0000);
    check("rd_p_error", p_error_o, 64'd0);
    check("rd_resp_psel", psel_o, 64'd0);
    @(negedge clk_i);
    check("rd_done_p_valid", p_valid_o, 64'd0);

    // 64b write split into two beats to slave 0
    issue(32'h1000_1008, 1'b1, AMO_NONE, 64'h1122_3344_5566_7788, 8'hFF, 2'd3);
    check("wr_b0_psel", psel_o, 64'h1);
    check("wr_b0_paddr", paddr_o, 64'h1000_1008);
    check("wr_b0_pwdata", pwdata_o, 64'h5566_7788);
    check("wr_b0_pstrb", pstrb_o, 64'hF);
    check("wr_b0_pwrite", pwrite_o, 64'd1);
    @(negedge clk_i);
    check("wr_b0_penable", penable_o, 64'd1);
    @(negedge clk_i);
    check("wr_b1_setup_penable", penable_o, 64'd0);
    check("wr_b1_psel", psel_o, 64'h1);
    check("wr_b1_paddr", paddr_o, 64'h1000_100C);
    check("wr_b1_pwdata", pwdata_o, 64'h1122_3344);
    check("wr_b1_pstrb", pstrb_o, 64'hF);
    @(negedge clk_i);
    check("wr_b1_penable", penable_o, 64'd1);
    check("wr_b1_p_valid_early", p_valid_o, 64'd0);
    @(negedge clk_i);
    check("wr_p_valid_c5", p_valid_o, 64'd1);
    check("wr_p_data", p_data_o, 64'd0);
    check("wr_p_error", p_error_o, 64'd0);
    @(negedge clk_i);

    // 64b read from slave 2 with pslverr on beat 0 only
    prdata_i = {32'hCAFE_0001, 64'd0};
    pslverr_i = 3'b100;
    issue(32'h1000_3000, 1'b0, AMO_NONE, 64'd0, 8'h00, 2'd3);
    check("err_b0_psel", psel_o, 64'h4);
    @(negedge clk_i);
    @(negedge clk_i);
    prdata_i = {32'hCAFE_0002, 64'd0};
    pslverr_i = 3'b000;
    check("err_b1_psel", psel_o, 64'h4);
    check("err_b1_paddr", paddr_o, 64'h1000_3004);
    @(negedge clk_i);
    @(negedge clk_i);
    check("err_p_valid", p_valid_o, 64'd1);
    check("err_p_data", p_data_o, 64'hCAFE_0002_CAFE_0001);
    check("err_p_error", p_error_o, 64'd1);
    @(negedge clk_i);

    // Decode miss, then AMO: no APB activity, error response
    for (int t = 0; t < 2; t++) begin
      p_ready_i = 1'b0;
      if (t == 0) issue(32'h2000_0000, 1'b0, AMO_NONE, 64'd0, 8'h00, 2'd2);
      else issue(32'h1000_1000, 1'b1, AMO_ADD, 64'h55, 8'h0F, 2'd2);
      check(t == 0 ? "miss_c1_psel" : "amo_c1_psel", psel_o, 64'd0);
      @(negedge clk_i);
      check(t == 0 ? "miss_psel" : "amo_psel", psel_o, 64'd0);
      check(t == 0 ? "miss_p_valid" : "amo_p_valid", p_valid_o, 64'd1);
      check(t == 0 ? "miss_p_error" : "amo_p_error", p_error_o, 64'd1);
      check(t == 0 ? "miss_p_data" : "amo_p_data", p_data_o, 64'd0);
      p_ready_i = 1'b1;
      @(negedge clk_i);
      check(t == 0 ? "miss_done" : "amo_done", p_valid_o, 64'd0);
    end

    // Timeout: slave 0 never ready, 4 ACCESS cycles then error
    pready_i = 3'b110;
    issue(32'h1000_1000, 1'b0, AMO_NONE, 64'd0, 8'h00, 2'd2);
    check("to_setup_penable", penable_o, 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check("to_access_psel", psel_o, 64'h1);
      check("to_access_penable", penable_o, 64'd1);
    end
    @(negedge clk_i);
    check("to_psel_drop", psel_o, 64'd0);
    check("to_penable_drop", penable_o, 64'd0);
    check("to_p_valid", p_valid_o, 64'd1);
    check("to_p_error", p_error_o, 64'd1);
    @(negedge clk_i);
    pready_i = 3'b111;
    prdata_i = {64'd0, 32'h0BAD_F00D};
    issue(32'h1000_1000, 1'b0, AMO_NONE, 64'd0, 8'h00, 2'd2);
    @(negedge clk_i);
    @(negedge clk_i);
    check("after_to_p_valid", p_valid_o, 64'd1);
    check("after_to_p_data", p_data_o, 64'h0000_0000_0BAD_F00D);
    check("after_to_p_error", p_error_o, 64'd0);
    @(negedge clk_i);

    // Response back-pressure for 10 cycles
    p_ready_i = 1'b0;
    prdata_i = {32'd0, 32'h1234_5678, 32'd0};
    issue(32'h1000_2000, 1'b0, AMO_NONE, 64'd0, 8'h00, 2'd2);
    @(negedge clk_i);
    @(negedge clk_i);
    for (int c = 0; c < 10; c++) begin
      check("hold_p_valid", p_valid_o, 64'd1);
      check("hold_p_data", p_data_o, 64'h1234_5678);
      check("hold_p_error", p_error_o, 64'd0);
      check("hold_q_ready", q_ready_o, 64'd0);
      @(negedge clk_i);
    end
    p_ready_i = 1'b1;
    @(negedge clk_i);
    check("hold_release_p_valid", p_valid_o, 64'd0);
    check("hold_release_q_ready", q_ready_o, 64'd1);

    // Asynchronous reset during ACCESS of a write
    issue(32'h1000_2000, 1'b1, AMO_NONE, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 2'd2);
    check("rst_setup_pwrite", pwrite_o, 64'd1);
    @(negedge clk_i);
    check("rst_access_penable", penable_o, 64'd1);
    check("rst_access_pwdata", pwdata_o, 64'hCCCC_DDDD);
    #1 rst_ni = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_q_ready", q_ready_o, 64'd1);
    check("post_rst_p_valid", p_valid_o, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cc_reqrsp_to_apb_bridge.md
Name: cc_reqrsp_to_apb_bridge

Overview:
Parametrised bridge from one reqrsp port (REQ_DATA_WIDTH data) to N APB2.0/AMBA4 completers (APB_DATA_WIDTH data) in the CoreComplex peripheral path. It generalises the fixed 64b-reqrsp / 32b-APB / 3-slave pairing. New behaviour:
- configurable slave count and address map;
- splitting of wide accesses into multiple APB beats;
- AMO rejection;
- a per-transfer timeout.
Only one transaction is outstanding at a time.

Parameters:
NUM_APB_SLV, 3, number of APB completers (1..16)
ADDR_WIDTH, 32, address width
REQ_DATA_WIDTH, 64, reqrsp data width (power of 2, >= APB_DATA_WIDTH)
APB_DATA_WIDTH, 32, APB data width (32 or 64)
SLV_BASE, {32'h1000_3000,32'h1000_2000,32'h1000_1000}, packed NUM_APB_SLV*ADDR_WIDTH base addresses, slave 0 in the LSBs
SLV_MASK, {3{32'hFFFF_F000}}, packed NUM_APB_SLV*ADDR_WIDTH decode masks
TIMEOUT_CYCLES, 256, maximum ACCESS cycles per beat; 0 disables the timeout
Derived: RATIO=REQ_DATA_WIDTH/APB_DATA_WIDTH; ABYTES=APB_DATA_WIDTH/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
q_addr_i  in  ADDR_WIDTH  request address
q_write_i  in  1  1 = write
q_amo_i  in  4  reqrsp_pkg::amo_op_e
q_data_i  in  REQ_DATA_WIDTH  write data
q_strb_i  in  REQ_DATA_WIDTH/8  write strobes
q_size_i  in  2  log2 of access bytes
q_valid_i  in  1  request valid
q_ready_o  out  1  request accepted
p_data_o  out  REQ_DATA_WIDTH  read data
p_error_o  out  1  response error
p_valid_o  out  1  response valid
p_ready_i  in  1  response accepted
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection (constant 3'b000)
psel_o  out  NUM_APB_SLV  one-hot select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
pwdata_o  out  APB_DATA_WIDTH  APB write data
pstrb_o  out  ABYTES  APB strobes
prdata_i  in  NUM_APB_SLV*APB_DATA_WIDTH  per-slave read data
pready_i  in  NUM_APB_SLV  per-slave ready
pslverr_i  in  NUM_APB_SLV  per-slave error

Behaviour:
- Clock/reset: clk_i, rst_ni. Reset is asynchronous, active-low. Outputs at reset: all outputs 0, FSM in IDLE.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - q_ready_o=1.
  - On q_valid_i, latch the request, compute decode/beats, and accept (q_ready_o is combinational in IDLE only).
  - AMO != AMO_NONE, or decode miss: go directly to RESP with error=1 and data 0. No APB activity.
  - Otherwise go to SETUP with beat=0.
- Decode: slave i hits when (addr & MASK[i]) == BASE[i]. On multiple hits the lowest index wins.
- Beats:
  - size <= log2(ABYTES): 1 beat at addr aligned to ABYTES; lane = addr[log2(REQ bytes)-1:log2(ABYTES)].
  - Otherwise: (1<<size)/ABYTES beats starting at addr aligned to REQ bytes, lanes 0..n-1.
- Beat address = aligned base + beat*ABYTES. pwdata/pstrb are taken from the matching lane of the latched data/strb. Reads drive pstrb=0.
- SETUP: psel[i]=1, penable=0, paddr/pwrite/pwdata/pstrb valid. Next cycle go to ACCESS.
- ACCESS:
  - psel[i]=1, penable=1; all APB outputs held stable.
  - When pready_i[i]=1:
    - Capture prdata_i[i] into its lane (reads).
    - OR pslverr_i[i] into the error flag.
    - If this was the last beat, go to RESP; else beat++ and go to SETUP.
  - pslverr does not abort the remaining beats.
- Timeout:
  - Counter clears on SETUP and counts in ACCESS.
  - When it reaches TIMEOUT_CYCLES without pready: drop psel/penable, set error, go to RESP, skip remaining beats.
  - TIMEOUT_CYCLES=0 disables the timeout.
- RESP:
  - p_valid_o=1; p_data_o/p_error_o held stable until p_ready_i.
  - On handshake go to IDLE.
  - A new q is not accepted in the same cycle (q_ready_o=0 in RESP).
- Read data lanes not covered by any beat are 0. Write responses return p_data_o=0.
- Latency for a single-beat access with pready already high:
  - q handshake in cycle 0;
  - SETUP in cycle 1;
  - ACCESS in cycle 2;
  - p_valid in cycle 3.
  - Each extra beat adds 2 cycles; each pready wait cycle adds 1.
- Reset mid-transfer: psel/penable/p_valid drop immediately and the transaction is lost. Software must not rely on completion.
- When a selected slave's pready is already 1 in SETUP, it is ignored; only ACCESS samples pready.
- Beat counter width is $clog2(RATIO)+1. The timeout counter saturates.

Decomposition:
- CC_ITF_PKG gains:
  - the apb_dw-parametrised req/resp struct pattern;
  - the default SLV_BASE/SLV_MASK localparams (APB_SLV_NUM map);
  - the apb_bridge_state_e enum {IDLE, SETUP, ACCESS, RESP}.
- One sub-module: cc_apb_addr_decode (combinational address-to-one-hot decode plus hit flag), reused by other APB fabrics.

Test Plan:
- 32b read, addr 0x1000_2004, size 2, slave 1 prdata=0xDEAD_BEEF, pready=1 → one SETUP/ACCESS to slave 1, paddr 0x1000_2004; p_data_o=0xDEAD_BEEF_0000_0000, p_error=0, p_valid in cycle 3.
- 64b write, addr 0x1000_1008, data 0x1122_3344_5566_7788, strb 0xFF → two beats to slave 0: 0x1000_1008 with pwdata 0x5566_7788, then 0x1000_100C with pwdata 0x1122_3344; pstrb 0xF both; p_valid in cycle 5.
- 64b read, slave 2, beat 0 pslverr=1 → beat 1 still issued; p_error_o=1, both lanes captured.
- Address 0x2000_0000 (no hit), and separately amo=AMO_ADD → no psel asserted; p_valid with p_error_o=1 two cycles after the handshake.
- TIMEOUT_CYCLES=4, pready held 0 → psel drops after 4 ACCESS cycles; p_error_o=1; the next request completes normally.
- p_ready_i held 0 for 10 cycles, and rst_ni asserted during ACCESS → response held stable with q_ready_o=0 throughout; on reset all outputs 0 asynchronously.
